fetch_prefetch_unit: RTL and testbench
======================================

// Module: fetch_prefetch_unit
// PURPOSE
//  Decoupled instruction-fetch front end. Issues sequential word fetches to a
//  pipelined instruction memory, buffers returned instructions with their PCs
//  in a DEPTH-entry queue, and hands them to decode over valid/ready. A branch
//  redirect flushes the queue and discards in-flight responses. Sits between
//  the PC source/branch unit and decode.
// PARAMETERS
//  XLEN            32  address/PC width
//  DEPTH           4   prefetch queue entries (power of 2, >=2)
//  MAX_OUTSTANDING 2   max memory requests in flight (1..DEPTH)
//  RESET_PC        0   first fetch address after reset (word aligned)
// PORTS
//  clk             in   1     clock, rising edge
//  rst             in   1     reset, asynchronous, active-high
//  redirect_valid  in   1     branch/jump taken this cycle
//  redirect_pc     in   XLEN  new fetch target ([1:0] ignored, forced 0)
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  fetch address
//  imem_resp_valid in   1     in-order response valid (no backpressure)
//  imem_resp_data  in   32    fetched instruction word
//  out_valid       out  1     queue head valid to decode
//  out_ready       in   1     decode accepts head
//  out_instr       out  32    head instruction
//  out_pc          out  XLEN  PC of head instruction
// BEHAVIOUR
//  Reset: fetch_pc=resp_pc=RESET_PC; queue empty; outstanding=drop_cnt=0;
//   out_valid=0, imem_req_valid=0, out_instr=0, out_pc=0, imem_req_addr=RESET_PC.
//  Issue: imem_req_valid = !redirect_valid && outstanding<MAX_OUTSTANDING &&
//   (count+outstanding)<DEPTH (credit: every response has a guaranteed slot).
//   imem_req_addr=fetch_pc. On valid&ready: fetch_pc+=4 (wraps mod 2^XLEN),
//   outstanding++. Request, once valid, holds addr stable until accepted or redirect.
//  Response: each imem_resp_valid decrements outstanding. If drop_cnt>0: data
//   discarded, drop_cnt--. Else push {resp_pc, data}; resp_pc+=4.
//   Response with outstanding==0 ignored (protocol error, no state change).
//  Output: out_valid=(count!=0); out_instr/out_pc = head entry, combinational
//   from storage. Pop on out_valid&out_ready. Push+pop same cycle legal at any
//   count incl. full; count unchanged. Latency: response cycle N -> out_valid N+1.
//  Redirect (cycle N): queue flushed (out_valid=0 in N+1); fetch_pc and resp_pc
//   <= {redirect_pc[XLEN-1:2],2'b00}; no request issued in N; response in N
//   discarded; drop_cnt <= outstanding - imem_resp_valid (all remaining in flight);
//   first request to redirect target in N+1. A decode handshake in N completes;
//   decode owns killing that younger instruction. Back-to-back redirects: last wins,
//   drop_cnt recomputed each time.
//  Reset mid-operation: all state cleared immediately; memory is reset alongside.
// STRUCTURE
//  fetch_pkg: INSTR_W=32, NOP_INSTR=32'h0000_0013, PC_STEP=4, fetch_entry
//   typedef {pc[XLEN-1:0], instr[31:0]}.
//  Sub-module fetch_queue: DEPTH-entry circular FIFO, wr/rd pointers with wrap,
//   count, synchronous flush, push/pop, head output. Top holds PC regs, credit
//   logic, outstanding/drop counters.
// TESTING
//  Reset, req_ready=1, 1-cycle memory: out stream pc 0,4,8,C with matching
//   words; out_valid first high 2 cycles after first request.
//  out_ready=0: exactly DEPTH=4 entries fill, then imem_req_valid=0; out_ready=1
//   resumes with no lost/duplicated PC.
//  Redirect to 0x100 with 2 requests in flight: both responses dropped, next
//   out_pc=0x100, out_valid low in cycle after redirect.
//  Redirect to 0x203: imem_req_addr=0x200, out_pc=0x200.
//  Redirect on two consecutive cycles (0x40 then 0x80): only 0x80 stream emerges.
//  Random req_ready/resp delay/out_ready: scoreboard in-order PCs, outstanding
//   never >MAX_OUTSTANDING, no queue overflow; fetch_pc wrap 0xFFFFFFFC->0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and the queue entry layout for the instruction-fetch front end.
package fetch_pkg;
    localparam int INSTR_W          = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int PC_STEP          = 4;
    localparam int XLEN_DEF         = 32;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [INSTR_W-1:0]  instr;
    } fetch_entry;
endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO holding fetched {pc, instr} entries; head is read straight from storage.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CW-1:0]     count
);
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic              empty, full, do_push, do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    // A full queue still takes a push when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || pop);
    assign do_pop  = pop && !flush && !empty;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    mem_reg[gi] <= '0;
                else if (do_push && wr_ptr_reg == AW'(gi))
                    mem_reg[gi] <= push_data;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;
endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: credit-limited sequential fetch, in-order response capture,
// redirect flush with discard of responses still in flight.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int             XLEN            = 32,
    parameter int             DEPTH           = 4,
    parameter int             MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC       = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = CW + 1;

    logic [XLEN-1:0] fetch_pc_reg, resp_pc_reg, redirect_target;
    logic [OW-1:0]   outstanding_reg, drop_cnt_reg, outstanding_next;
    logic [CW-1:0]   q_count;
    logic [SW-1:0]   credit_used;
    logic            req_fire, resp_fire, keep_resp, pop;

    assign redirect_target = redirect_pc & ~XLEN'(3);

    // Entries queued plus requests in flight never exceed DEPTH, so every
    // response is guaranteed a slot and memory needs no backpressure.
    assign credit_used    = SW'(q_count) + SW'(outstanding_reg);
    assign imem_req_valid = !rst && !redirect_valid
                            && (outstanding_reg < OW'(MAX_OUTSTANDING))
                            && (credit_used < SW'(DEPTH));
    assign imem_req_addr  = fetch_pc_reg;

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign resp_fire = imem_resp_valid && (outstanding_reg != '0);
    assign keep_resp = resp_fire && (drop_cnt_reg == '0) && !redirect_valid;

    assign outstanding_next = outstanding_reg + OW'(req_fire) - OW'(resp_fire);

    assign out_valid = (q_count != '0);
    assign pop       = out_valid && out_ready;

    fetch_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (XLEN + INSTR_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (keep_resp),
        .push_data ({resp_pc_reg, imem_resp_data}),
        .pop       (pop),
        .head      ({out_pc, out_instr}),
        .count     (q_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            if (redirect_valid) begin
                fetch_pc_reg <= redirect_target;
                resp_pc_reg  <= redirect_target;
                // Everything still in flight after this cycle belongs to the old path.
                drop_cnt_reg <= outstanding_reg - OW'(resp_fire);
            end else begin
                if (req_fire)
                    fetch_pc_reg <= fetch_pc_reg + XLEN'(PC_STEP);
                if (resp_fire) begin
                    if (drop_cnt_reg != '0)
                        drop_cnt_reg <= drop_cnt_reg - 1'b1;
                    else
                        resp_pc_reg <= resp_pc_reg + XLEN'(PC_STEP);
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomised bench for fetch_prefetch_unit: memory model with variable latency and a
// queue-level reference of what decode must see, compared every cycle.
module tb_fetch_prefetch_unit;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    always #5 clk = ~clk;

    fetch_prefetch_unit #(
        .XLEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    mreq_t       mem_q[$];      // requests accepted by memory, oldest first
    ent_t        mq[$];         // what decode should currently see queued
    logic [31:0] pop_log[$];
    logic [31:0] m_fetch_pc;
    int epoch, cyc, checks, errors;
    int min_delay, max_delay;
    int first_req, first_ov;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, then advance the model.
    task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy, input logic ordy);
        logic  exp_rv, exp_ov, resp;
        mreq_t r;
        int    infl;
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        out_ready      = ordy;
        resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? word_of(mem_q[0].addr) : $urandom;
        #1;
        infl   = mem_q.size();
        exp_rv = !redir && (infl < MAXO) && ((mq.size() + infl) < DEPTH);
        exp_ov = (mq.size() != 0);
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        check("req_addr", imem_req_addr, m_fetch_pc);
        check("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
        if (exp_ov) begin
            check("out_pc", out_pc, mq[0].pc);
            check("out_instr", out_instr, mq[0].instr);
        end
        if (imem_req_valid === 1'b1 && rdy && first_req < 0) first_req = cyc;
        if (out_valid === 1'b1 && first_ov < 0) first_ov = cyc;

        if (exp_ov && ordy) begin
            $display("cycle %0d pop pc=%h instr=%h", cyc, mq[0].pc, mq[0].instr);
            pop_log.push_back(mq[0].pc);
            void'(mq.pop_front());
        end
        if (resp) r = mem_q.pop_front();
        if (redir) begin
            epoch++;
            m_fetch_pc = {rpc[31:2], 2'b00};
            mq.delete();
        end else begin
            if (resp && r.epoch == epoch)
                mq.push_back('{pc: r.addr, instr: word_of(r.addr)});
            if (exp_rv && rdy) begin
                mem_q.push_back('{addr: m_fetch_pc, epoch: epoch,
                                  due: cyc + 1 + $urandom_range(max_delay, min_delay)});
                m_fetch_pc += 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0; imem_req_ready = 1'b0; out_ready = 1'b0;
        imem_resp_valid = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        mem_q.delete(); mq.delete(); pop_log.delete();
        m_fetch_pc = RESET_PC; epoch = 0;
        first_req = -1; first_ov = -1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_pops(input int n, input int budget);
        int start, k;
        start = pop_log.size();
        k = 0;
        while (pop_log.size() < start + n && k < budget) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            k++;
        end
        checks++;
        if (pop_log.size() < start + n) begin
            errors++;
            $display("FAIL run_pops: got %0d pops expected %0d within %0d cycles",
                     pop_log.size() - start, n, budget);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, k;
        checks = 0; errors = 0; cyc = 0; epoch = 0;
        min_delay = 0; max_delay = 0;
        m_fetch_pc = RESET_PC;

        // Single-cycle memory, always ready: stream 0,4,8,C.
        do_reset();
        run_pops(4, 20);
        for (int i = 0; i < 4; i++) check("seq_pc", pop_log[i], 32'(4 * i));
        check("first_valid_latency", 32'(first_ov - first_req), 32'd2);

        // Decode stalled: exactly DEPTH entries buffered, then fetch stops.
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        check("fill_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("fill_head_pc", out_pc, 32'h0);
        run_pops(8, 40);
        for (int i = 0; i < 8; i++) check("resume_pc", pop_log[i], 32'(4 * i));

        // Redirect with two requests in flight on a slow memory.
        do_reset();
        min_delay = 3; max_delay = 3;
        k = 0;
        while (mem_q.size() < 2 && k < 10) begin step(1'b0, 32'h0, 1'b1, 1'b1); k++; end
        check("inflight_before_redirect", 32'(mem_q.size()), 32'd2);
        step(1'b1, 32'h100, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("post_redirect_out_valid", {31'b0, out_valid}, 32'd0);
        idx = pop_log.size();
        min_delay = 0; max_delay = 1;
        run_pops(2, 40);
        check("redirect_first_pc", pop_log[idx], 32'h100);

        // Misaligned redirect target.
        step(1'b1, 32'h203, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("aligned_req_addr", imem_req_addr, 32'h200);
        idx = pop_log.size();
        run_pops(1, 40);
        check("aligned_out_pc", pop_log[idx], 32'h200);

        // Back-to-back redirects: the second wins.
        step(1'b1, 32'h40, 1'b1, 1'b1);
        step(1'b1, 32'h80, 1'b1, 1'b1);
        idx = pop_log.size();
        run_pops(2, 40);
        check("b2b_first_pc", pop_log[idx], 32'h80);
        check("b2b_second_pc", pop_log[idx + 1], 32'h84);

        // PC wraps past the top of the address space.
        step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        idx = pop_log.size();
        run_pops(3, 40);
        check("wrap_pc0", pop_log[idx], 32'hFFFF_FFF8);
        check("wrap_pc1", pop_log[idx + 1], 32'hFFFF_FFFC);
        check("wrap_pc2", pop_log[idx + 2], 32'h0000_0000);

        // Random traffic on every handshake.
        min_delay = 0; max_delay = 3;
        for (int i = 0; i < 3000; i++) begin
            logic        rd;
            logic [31:0] tgt;
            rd  = ($urandom_range(99) < 3);
            tgt = ($urandom_range(7) == 0) ? 32'hFFFF_FFF0 : $urandom;
            step(rd, tgt, $urandom_range(3) != 0, $urandom_range(3) != 0);
        end

        // Reset in the middle of traffic, then restart from RESET_PC.
        do_reset();
        run_pops(2, 40);
        check("post_reset_pc0", pop_log[0], RESET_PC);
        check("post_reset_pc1", pop_log[1], RESET_PC + 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
